add_vec_engine_ccip: RTL and testbench
======================================

// Module: add_vec_engine_ccip
// PURPOSE
//  Parametrised vector-add engine behind the AFU MMIO decode. Per cache line, it reads
//  operand line A and operand line B from host memory over CCI-P c0, then adds NUM_LANES
//  unsigned lanes of LANE_W bits. The result line is written to host memory over c1.
//  Runs over NUM_LINES consecutive lines. Reports busy/done/progress for MMIO readback.
// PARAMETERS
//  LANE_W     8   lane width in bits; NUM_LANES*LANE_W <= 512
//  NUM_LANES  64  lanes per 512b line; unused upper data bits are written as 0
//  SATURATE   0   0: lane sum wraps mod 2^LANE_W; 1: lane sum clamps to 2^LANE_W-1
//  CNT_W      16  width of the line counters; max job = 2^CNT_W-1 lines
// PORTS
//  clk             in   1    host_ccip.clk
//  reset_n         in   1    async active-low reset, host_ccip.reset_n
//  csr_wr_valid    in   1    MMIO write strobe, decoded by the parent
//  csr_wr_idx      in   3    0 SRC_A, 1 SRC_B, 2 DST (cl addr), 3 NUM_LINES, 4 START
//  csr_wr_data     in   64   MMIO write data
//  c0_req_valid    out  1    read request valid (one-cycle pulse per request)
//  c0_req_addr     out  42   read cache-line address
//  c0_req_mdata    out  16   tag: [0] 0=A 1=B; [15:1] 0
//  c0_almfull      in   1    host_ccip.sRx.c0TxAlmFull
//  c0_rsp_valid    in   1    read response valid (rspValid, resp_type RD)
//  c0_rsp_mdata    in   16   read response tag
//  c0_rsp_data     in   512  read response data
//  c1_req_valid    out  1    write request valid, sop=1, single beat
//  c1_req_addr     out  42   write cache-line address
//  c1_req_data     out  512  result line
//  c1_almfull      in   1    host_ccip.sRx.c1TxAlmFull
//  c1_rsp_valid    in   1    write response valid
//  busy            out  1    job active
//  done            out  1    sticky; cleared by next accepted START
//  lines_done      out  CNT_W  write responses received for the current job
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; config regs and counters 0.
//  Config writes (idx 0-3) are accepted in any state. They take effect at the next START.
//  START (idx 4, data ignored) is accepted only in IDLE or DONE and latches the config.
//  START while busy is ignored.
//  FSM:
//   IDLE/DONE -START-> RD_A. If NUM_LINES==0, START goes directly to DONE, done=1 the next cycle.
//   RD_A: when !c0_almfull, pulse c0 req addr=SRC_A+i, tag 0 -> RD_B.
//   RD_B: when !c0_almfull, pulse c0 req addr=SRC_B+i, tag 1 -> WAIT_RSP.
//   WAIT_RSP: capture a response into the A or B buffer by mdata[0]; responses may arrive in
//     either order or in the same cycle as RD_B. When both are captured -> WRITE.
//   WRITE: when !c1_almfull, pulse c1 req addr=DST+i, data=lane sums; i++.
//     Then -> RD_A if i<NUM_LINES, else -> DRAIN.
//   DRAIN: wait until lines_done==NUM_LINES -> DONE (busy=0, done=1).
//  lines_done increments on every c1_rsp_valid while busy. It saturates, with no wrap.
//  Address arithmetic is mod 2^42; wrap is silent.
//  Lane sum: with SATURATE=0, res[k]=(a[k]+b[k])[LANE_W-1:0]. With SATURATE=1, res[k] is the
//    all-ones value on carry out.
//  The adder is registered: the result is ready on the cycle after both operands are valid.
//    The first write may issue 1 cycle after entry to WRITE.
//  c0_rsp_valid outside WAIT_RSP/RD_B, or a duplicate tag, is dropped. The first capture wins.
//  Asserting reset mid-job aborts immediately. Late responses after reset are ignored,
//    because state is IDLE.
//  Backpressure: a request is never issued while its almfull is high. The state holds.
// STRUCTURE
//  Shared package add_vec_pkg: t_state enum, CSR index localparams, tag bit localparams.
//  Sub-module add_vec_lanes: NUM_LANES x LANE_W adder with SATURATE, plus one pipeline register.
//  Parent AFU maps host_ccip sRx/sTx to these ports and returns busy/done/lines_done on MMIO reads.
// TESTING
//  1. SRC_A, SRC_B, DST set, NUM_LINES=1, lanes a=0x03, b=0x05 -> one write to DST with each
//     lane=0x08; lines_done=1; done=1.
//  2. SATURATE=0: a=0xF0, b=0x20 -> lane=0x10. SATURATE=1: same operands -> lane=0xFF.
//  3. NUM_LINES=4, B response returned before A on line 2 -> 4 writes to DST..DST+3, all
//     correct, in order.
//  4. c0_almfull held 20 cycles in RD_A, c1_almfull held in WRITE -> no requests while high;
//     the job completes correctly after release.
//  5. NUM_LINES=0 START -> no c0/c1 traffic; done=1 after 1 cycle. START during busy -> ignored;
//     the config is unchanged.
//  6. reset_n low mid-job (line 2 of 8) -> all outputs 0 asynchronously; a new START afterwards
//     completes a fresh job.

Source files
------------

// File: rtl/add_vec_pkg.sv
// Shared types and constants for the CCI-P vector-add engine.
package add_vec_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WAIT_RSP,
    S_WRITE,
    S_DRAIN,
    S_DONE
  } t_state;

  localparam logic [2:0] CSR_SRC_A     = 3'd0;
  localparam logic [2:0] CSR_SRC_B     = 3'd1;
  localparam logic [2:0] CSR_DST       = 3'd2;
  localparam logic [2:0] CSR_NUM_LINES = 3'd3;
  localparam logic [2:0] CSR_START     = 3'd4;

  localparam int unsigned TAG_BIT = 0;
  localparam logic        TAG_A   = 1'b0;
  localparam logic        TAG_B   = 1'b1;

  localparam int unsigned CL_ADDR_W = 42;
  localparam int unsigned LINE_W    = 512;
  localparam int unsigned MDATA_W   = 16;

endpackage

// File: rtl/add_vec_lanes.sv
// NUM_LANES x LANE_W unsigned adder, optional clamp on carry out, one output register.
module add_vec_lanes #(
  parameter int unsigned LANE_W    = 8,
  parameter int unsigned NUM_LANES = 64,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid_i,
  input  logic [NUM_LANES*LANE_W-1:0]   a_i,
  input  logic [NUM_LANES*LANE_W-1:0]   b_i,
  output logic [NUM_LANES*LANE_W-1:0]   sum_o,
  output logic                          valid_o
);

  localparam int unsigned DW = NUM_LANES * LANE_W;

  logic [DW-1:0]   sum_d;
  logic [DW-1:0]   sum_q;
  logic            valid_q;
  logic [LANE_W:0] lane_sum;

  always_comb begin
    sum_d    = '0;
    lane_sum = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      lane_sum = {1'b0, a_i[k*LANE_W +: LANE_W]} + {1'b0, b_i[k*LANE_W +: LANE_W]};
      if ((SATURATE != 0) && lane_sum[LANE_W]) begin
        sum_d[k*LANE_W +: LANE_W] = '1;
      end else begin
        sum_d[k*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= in_valid_i;
    end
  end

  assign sum_o   = sum_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/add_vec_engine_ccip.sv
// Vector-add engine: reads lines A and B over CCI-P c0, writes lane sums over c1,
// for NUM_LINES consecutive cache lines.
module add_vec_engine_ccip
  import add_vec_pkg::*;
#(
  parameter int unsigned LANE_W    = 8,
  parameter int unsigned NUM_LANES = 64,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 csr_wr_valid,
  input  logic [2:0]           csr_wr_idx,
  input  logic [63:0]          csr_wr_data,
  output logic                 c0_req_valid,
  output logic [41:0]          c0_req_addr,
  output logic [15:0]          c0_req_mdata,
  input  logic                 c0_almfull,
  input  logic                 c0_rsp_valid,
  input  logic [15:0]          c0_rsp_mdata,
  input  logic [511:0]         c0_rsp_data,
  output logic                 c1_req_valid,
  output logic [41:0]          c1_req_addr,
  output logic [511:0]         c1_req_data,
  input  logic                 c1_almfull,
  input  logic                 c1_rsp_valid,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     lines_done
);

  localparam int unsigned DW = NUM_LANES * LANE_W;

  t_state state_q, state_d;

  logic [CL_ADDR_W-1:0] cfg_src_a_q, cfg_src_b_q, cfg_dst_q;
  logic [CNT_W-1:0]     cfg_num_q;
  logic [CL_ADDR_W-1:0] job_src_a_q, job_src_b_q, job_dst_q;
  logic [CNT_W-1:0]     job_num_q;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     lines_q;
  logic                 have_a_q, have_b_q;
  logic [DW-1:0]        buf_a_q, buf_b_q;
  logic [DW-1:0]        sum;
  logic                 sum_valid;
  logic                 start_ok, rsp_ours, cap_a, cap_b, wr_fire;

  assign start_ok = csr_wr_valid && (csr_wr_idx == CSR_START) &&
                    ((state_q == S_IDLE) || (state_q == S_DONE));

  // Responses only count while a read pair is outstanding; foreign tags are dropped.
  assign rsp_ours = c0_rsp_valid && (c0_rsp_mdata[MDATA_W-1:1] == '0) &&
                    ((state_q == S_RD_B) || (state_q == S_WAIT_RSP));
  assign cap_a    = rsp_ours && (c0_rsp_mdata[TAG_BIT] == TAG_A) && !have_a_q;
  assign cap_b    = rsp_ours && (c0_rsp_mdata[TAG_BIT] == TAG_B) && !have_b_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_src_a_q <= '0;
      cfg_src_b_q <= '0;
      cfg_dst_q   <= '0;
      cfg_num_q   <= '0;
      job_src_a_q <= '0;
      job_src_b_q <= '0;
      job_dst_q   <= '0;
      job_num_q   <= '0;
    end else begin
      if (csr_wr_valid) begin
        case (csr_wr_idx)
          CSR_SRC_A:     cfg_src_a_q <= csr_wr_data[CL_ADDR_W-1:0];
          CSR_SRC_B:     cfg_src_b_q <= csr_wr_data[CL_ADDR_W-1:0];
          CSR_DST:       cfg_dst_q   <= csr_wr_data[CL_ADDR_W-1:0];
          CSR_NUM_LINES: cfg_num_q   <= csr_wr_data[CNT_W-1:0];
          default: ;
        endcase
      end
      if (start_ok) begin
        job_src_a_q <= cfg_src_a_q;
        job_src_b_q <= cfg_src_b_q;
        job_dst_q   <= cfg_dst_q;
        job_num_q   <= cfg_num_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lines_q  <= '0;
      have_a_q <= 1'b0;
      have_b_q <= 1'b0;
      buf_a_q  <= '0;
      buf_b_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (start_ok) begin
        lines_q <= '0;
      end else if (c1_rsp_valid && busy && (lines_q != '1)) begin
        lines_q <= lines_q + 1'b1;
      end
      if (start_ok || wr_fire) begin
        have_a_q <= 1'b0;
        have_b_q <= 1'b0;
      end else begin
        if (cap_a) have_a_q <= 1'b1;
        if (cap_b) have_b_q <= 1'b1;
      end
      if (cap_a) buf_a_q <= c0_rsp_data[DW-1:0];
      if (cap_b) buf_b_q <= c0_rsp_data[DW-1:0];
    end
  end

  add_vec_lanes #(
    .LANE_W    (LANE_W),
    .NUM_LANES (NUM_LANES),
    .SATURATE  (SATURATE)
  ) u_lanes (
    .clk        (clk),
    .rst_n      (reset_n),
    .in_valid_i (have_a_q & have_b_q),
    .a_i        (buf_a_q),
    .b_i        (buf_b_q),
    .sum_o      (sum),
    .valid_o    (sum_valid)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_fire      = 1'b0;
    c0_req_valid = 1'b0;
    c0_req_addr  = '0;
    c0_req_mdata = '0;
    c1_req_valid = 1'b0;
    c1_req_addr  = '0;
    c1_req_data  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          idx_d   = '0;
          state_d = (cfg_num_q == '0) ? S_DONE : S_RD_A;
        end
      end
      S_RD_A: begin
        if (!c0_almfull) begin
          c0_req_valid          = 1'b1;
          c0_req_addr           = job_src_a_q + CL_ADDR_W'(idx_q);
          c0_req_mdata[TAG_BIT] = TAG_A;
          state_d               = S_RD_B;
        end
      end
      S_RD_B: begin
        if (!c0_almfull) begin
          c0_req_valid          = 1'b1;
          c0_req_addr           = job_src_b_q + CL_ADDR_W'(idx_q);
          c0_req_mdata[TAG_BIT] = TAG_B;
          state_d               = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (have_a_q && have_b_q) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (sum_valid && !c1_almfull) begin
          wr_fire                 = 1'b1;
          c1_req_valid            = 1'b1;
          c1_req_addr             = job_dst_q + CL_ADDR_W'(idx_q);
          c1_req_data[DW-1:0]     = sum;
          idx_d                   = idx_q + 1'b1;
          state_d                 = (idx_d < job_num_q) ? S_RD_A : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (lines_q == job_num_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign lines_done = lines_q;

endmodule

// File: tb/tb_add_vec_engine_ccip.sv
// Directed bench for add_vec_engine_ccip: host memory model, request scoreboard, lane-sum model.
module tb_add_vec_engine_ccip;

  localparam int LW = 8;
  localparam int NL = 64;
  localparam int CW = 16;
  localparam int MAXV = (1 << LW) - 1;

  typedef struct {
    logic [41:0] addr;
    logic        tag;
  } rd_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          csr_wr_valid;
  logic [2:0]    csr_wr_idx;
  logic [63:0]   csr_wr_data;
  logic          c0_almfull, c0_rsp_valid, c1_almfull, c1_rsp_valid;
  logic [15:0]   c0_rsp_mdata;
  logic [511:0]  c0_rsp_data;

  logic          c0_req_valid, c1_req_valid, busy, done;
  logic [41:0]   c0_req_addr, c1_req_addr;
  logic [15:0]   c0_req_mdata;
  logic [511:0]  c1_req_data;
  logic [CW-1:0] lines_done;

  logic          s_c0_req_valid, s_c1_req_valid, s_busy, s_done;
  logic [41:0]   s_c0_req_addr, s_c1_req_addr;
  logic [15:0]   s_c0_req_mdata;
  logic [511:0]  s_c1_req_data;
  logic [CW-1:0] s_lines_done;

  always #5 clk = ~clk;

  add_vec_engine_ccip #(.LANE_W(LW), .NUM_LANES(NL), .SATURATE(0), .CNT_W(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .csr_wr_valid(csr_wr_valid), .csr_wr_idx(csr_wr_idx),
    .csr_wr_data(csr_wr_data), .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr),
    .c0_req_mdata(c0_req_mdata), .c0_almfull(c0_almfull), .c0_rsp_valid(c0_rsp_valid),
    .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data), .c1_req_valid(c1_req_valid),
    .c1_req_addr(c1_req_addr), .c1_req_data(c1_req_data), .c1_almfull(c1_almfull),
    .c1_rsp_valid(c1_rsp_valid), .busy(busy), .done(done), .lines_done(lines_done)
  );

  add_vec_engine_ccip #(.LANE_W(LW), .NUM_LANES(NL), .SATURATE(1), .CNT_W(CW)) u_sat (
    .clk(clk), .reset_n(reset_n), .csr_wr_valid(csr_wr_valid), .csr_wr_idx(csr_wr_idx),
    .csr_wr_data(csr_wr_data), .c0_req_valid(s_c0_req_valid), .c0_req_addr(s_c0_req_addr),
    .c0_req_mdata(s_c0_req_mdata), .c0_almfull(c0_almfull), .c0_rsp_valid(c0_rsp_valid),
    .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data), .c1_req_valid(s_c1_req_valid),
    .c1_req_addr(s_c1_req_addr), .c1_req_data(s_c1_req_data), .c1_almfull(c1_almfull),
    .c1_rsp_valid(c1_rsp_valid), .busy(s_busy), .done(s_done), .lines_done(s_lines_done)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [511:0] mem [logic [41:0]];
  rd_t          exp_rd[$];
  logic [41:0]  exp_wa[$];
  logic [511:0] exp_wd[$];
  logic [511:0] exp_sd[$];
  rd_t          rdq[$];
  rd_t          rd_e;

  logic [41:0]  cfg_a, cfg_b, cfg_d;
  int           cfg_n;
  logic [41:0]  swap_addr = '1;
  bit           start_accept = 1'b0;
  int           model_lines = 0;
  int           rd_cnt = 0, wr_cnt = 0, wr_pending = 0;
  logic [41:0]  last_wa;
  logic [511:0] last_wd, last_sd;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got unexpected event, want none", nm);
  endtask

  function automatic logic [511:0] rd_mem(input logic [41:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  function automatic logic [511:0] vsum(input logic [511:0] a, input logic [511:0] b, input bit sat);
    logic [511:0] r;
    int unsigned  s;
    r = '0;
    for (int k = 0; k < NL; k++) begin
      s = a[k*LW +: LW] + b[k*LW +: LW];
      if (s > MAXV) s = sat ? MAXV : s - (MAXV + 1);
      r[k*LW +: LW] = s[LW-1:0];
    end
    return r;
  endfunction

  task automatic fill(input logic [41:0] addr, input logic [7:0] base, input int step);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < NL; k++) l[k*LW +: LW] = base + 8'(k * step);
    mem[addr] = l;
  endtask

  task automatic csr_wr(input logic [2:0] idx, input logic [63:0] data);
    @(posedge clk); #1;
    csr_wr_valid = 1'b1;
    csr_wr_idx   = idx;
    csr_wr_data  = data;
    @(posedge clk); #1;
    csr_wr_valid = 1'b0;
  endtask

  task automatic write_cfg(input logic [41:0] a, input logic [41:0] b, input logic [41:0] d, input int n);
    cfg_a = a; cfg_b = b; cfg_d = d; cfg_n = n;
    csr_wr(3'd0, 64'(a));
    csr_wr(3'd1, 64'(b));
    csr_wr(3'd2, 64'(d));
    csr_wr(3'd3, 64'(n));
  endtask

  task automatic do_start(input bit accept);
    logic [41:0] la, lb;
    start_accept = accept;
    if (accept) begin
      for (int i = 0; i < cfg_n; i++) begin
        la = 42'(cfg_a + 42'(i));
        lb = 42'(cfg_b + 42'(i));
        exp_rd.push_back('{addr: la, tag: 1'b0});
        exp_rd.push_back('{addr: lb, tag: 1'b1});
        exp_wa.push_back(42'(cfg_d + 42'(i)));
        exp_wd.push_back(vsum(rd_mem(la), rd_mem(lb), 1'b0));
        exp_sd.push_back(vsum(rd_mem(la), rd_mem(lb), 1'b1));
      end
    end
    csr_wr(3'd4, 64'h0);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 512'(done), 512'(1));
  endtask

  // Scoreboard and lines_done model; checks happen before the model absorbs this cycle's inputs.
  always @(negedge clk) begin
    if (!reset_n) begin
      model_lines = 0;
    end else begin
      if (c0_req_valid) begin
        rd_cnt++;
        chk("c0_req_under_almfull", 512'(c0_almfull), 512'(0));
        if (exp_rd.size() == 0) fail_evt("c0_req_unexpected");
        else begin
          rd_e = exp_rd.pop_front();
          chk("c0_req_addr", 512'(c0_req_addr), 512'(rd_e.addr));
          chk("c0_req_mdata", 512'(c0_req_mdata), 512'({15'b0, rd_e.tag}));
        end
        rdq.push_back('{addr: c0_req_addr, tag: c0_req_mdata[0]});
      end
      if (c1_req_valid) begin
        wr_cnt++;
        wr_pending++;
        last_wa = c1_req_addr;
        last_wd = c1_req_data;
        chk("c1_req_under_almfull", 512'(c1_almfull), 512'(0));
        if (exp_wa.size() == 0) fail_evt("c1_req_unexpected");
        else begin
          chk("c1_req_addr", 512'(c1_req_addr), 512'(exp_wa.pop_front()));
          chk("c1_req_data", c1_req_data, exp_wd.pop_front());
        end
      end
      if (s_c1_req_valid) begin
        last_sd = s_c1_req_data;
        if (exp_sd.size() == 0) fail_evt("sat_c1_req_unexpected");
        else chk("sat_c1_req_data", s_c1_req_data, exp_sd.pop_front());
      end
      chk("lines_done", 512'(lines_done), 512'(model_lines));
      if (csr_wr_valid && csr_wr_idx == 3'd4 && start_accept) model_lines = 0;
      if (c1_rsp_valid) model_lines++;
    end
  end

  // Host read port: answers each A/B pair, optionally B first for the selected A address.
  initial begin
    rd_t p0, p1, t;
    c0_rsp_valid = 1'b0;
    c0_rsp_mdata = '0;
    c0_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      c0_rsp_valid = 1'b0;
      if (rdq.size() >= 2) begin
        p0 = rdq.pop_front();
        p1 = rdq.pop_front();
        if (p0.addr == swap_addr) begin
          t = p0; p0 = p1; p1 = t;
        end
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = {15'b0, p0.tag};
        c0_rsp_data  = rd_mem(p0.addr);
        @(posedge clk); #1;
        c0_rsp_mdata = {15'b0, p1.tag};
        c0_rsp_data  = rd_mem(p1.addr);
      end
    end
  end

  initial begin
    c1_rsp_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      c1_rsp_valid = 1'b0;
      if (wr_pending > 0) begin
        c1_rsp_valid = 1'b1;
        wr_pending--;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, c;
    reset_n = 1'b1; csr_wr_valid = 1'b0; csr_wr_idx = '0; csr_wr_data = '0;
    c0_almfull = 1'b0; c1_almfull = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 512'({c0_req_valid, c1_req_valid, busy, done, lines_done, c0_req_addr}), 512'(0));
    reset_n = 1'b1;

    // Basic one-line job
    fill(42'h100, 8'h03, 0);
    fill(42'h200, 8'h05, 0);
    write_cfg(42'h100, 42'h200, 42'h300, 1);
    do_start(1'b1);
    wait_done("t1_done", 500);
    chk("t1_busy", 512'(busy), 512'(0));
    chk("t1_lines_done", 512'(lines_done), 512'(1));
    chk("t1_wr_addr", 512'(last_wa), 512'(42'h300));
    chk("t1_wr_data", last_wd, {64{8'h08}});
    chk("t1_wr_left", 512'(exp_wa.size()), 512'(0));

    // Wrap versus clamp
    fill(42'h110, 8'hF0, 0);
    fill(42'h210, 8'h20, 0);
    write_cfg(42'h110, 42'h210, 42'h310, 1);
    do_start(1'b1);
    wait_done("t2_done", 500);
    chk("t2_wrap_data", last_wd, {64{8'h10}});
    chk("t2_sat_data", last_sd, {64{8'hFF}});

    // Four lines, B answered before A on the second line
    for (int i = 0; i < 4; i++) begin
      fill(42'h1000 + 42'(i), 8'(i * 16), 1);
      fill(42'h2000 + 42'(i), 8'(8'hC0 + i), 1);
    end
    swap_addr = 42'h1001;
    w0 = wr_cnt;
    write_cfg(42'h1000, 42'h2000, 42'h3000, 4);
    do_start(1'b1);
    wait_done("t3_done", 1000);
    swap_addr = '1;
    chk("t3_write_count", 512'(wr_cnt - w0), 512'(4));
    chk("t3_lines_done", 512'(lines_done), 512'(4));
    chk("t3_wr_addr", 512'(last_wa), 512'(42'h3003));
    chk("t3_lane0", 512'(last_wd[7:0]), 512'(8'hF3));
    chk("t3_lane10_wrap", 512'(last_wd[80 +: 8]), 512'(8'h07));
    chk("t3_lane10_sat", 512'(last_sd[80 +: 8]), 512'(8'hFF));
    chk("t3_lane63", 512'(last_wd[504 +: 8]), 512'(8'h71));

    // Backpressure on both channels
    for (int i = 0; i < 2; i++) begin
      fill(42'h4000 + 42'(i), 8'(8'h11 * i), 3);
      fill(42'h5000 + 42'(i), 8'h7F, 2);
    end
    write_cfg(42'h4000, 42'h5000, 42'h6000, 2);
    c0_almfull = 1'b1;
    c1_almfull = 1'b1;
    r0 = rd_cnt; w0 = wr_cnt;
    do_start(1'b1);
    repeat (20) @(negedge clk);
    chk("t4_no_rd_while_almfull", 512'(rd_cnt - r0), 512'(0));
    chk("t4_busy_held", 512'(busy), 512'(1));
    @(posedge clk); #1 c0_almfull = 1'b0;
    repeat (30) @(negedge clk);
    chk("t4_rd_after_release", 512'(rd_cnt - r0), 512'(2));
    chk("t4_no_wr_while_almfull", 512'(wr_cnt - w0), 512'(0));
    @(posedge clk); #1 c1_almfull = 1'b0;
    wait_done("t4_done", 1000);
    chk("t4_write_count", 512'(wr_cnt - w0), 512'(2));
    chk("t4_lines_done", 512'(lines_done), 512'(2));

    // Empty job, then START while busy
    write_cfg(42'h7000, 42'h7100, 42'h7200, 0);
    r0 = rd_cnt; w0 = wr_cnt;
    do_start(1'b1);
    @(negedge clk);
    chk("t5_zero_done", 512'(done), 512'(1));
    chk("t5_zero_busy", 512'(busy), 512'(0));
    repeat (5) @(negedge clk);
    chk("t5_zero_traffic", 512'({rd_cnt - r0, wr_cnt - w0}), 512'(0));
    chk("t5_zero_lines", 512'(lines_done), 512'(0));
    for (int i = 0; i < 3; i++) begin
      fill(42'h8000 + 42'(i), 8'(8'h21 + i), 1);
      fill(42'h8100 + 42'(i), 8'(8'hE0 - i), 2);
      fill(42'h9000 + 42'(i), 8'h40, 1);
      fill(42'h9100 + 42'(i), 8'h01, 0);
    end
    w0 = wr_cnt;
    write_cfg(42'h8000, 42'h8100, 42'h8200, 3);
    do_start(1'b1);
    write_cfg(42'h9000, 42'h9100, 42'h9200, 2);
    chk("t5_busy_before_restart", 512'(busy), 512'(1));
    do_start(1'b0);
    wait_done("t5_busy_job_done", 1000);
    chk("t5_busy_job_writes", 512'(wr_cnt - w0), 512'(3));
    chk("t5_busy_job_lines", 512'(lines_done), 512'(3));
    chk("t5_busy_job_last_addr", 512'(last_wa), 512'(42'h8202));
    w0 = wr_cnt;
    do_start(1'b1);
    wait_done("t5_new_cfg_done", 1000);
    chk("t5_new_cfg_writes", 512'(wr_cnt - w0), 512'(2));
    chk("t5_new_cfg_addr", 512'(last_wa), 512'(42'h9201));

    // Reset in the middle of an eight-line job
    for (int i = 0; i < 8; i++) begin
      fill(42'hA000 + 42'(i), 8'(i), 1);
      fill(42'hB000 + 42'(i), 8'h10, 0);
    end
    w0 = wr_cnt;
    write_cfg(42'hA000, 42'hB000, 42'hC000, 8);
    do_start(1'b1);
    c = 0;
    while (wr_cnt - w0 < 1 && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("t6_first_write_seen", 512'(wr_cnt - w0), 512'(1));
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_reset_outputs",
        512'({c0_req_valid, c1_req_valid, busy, done, lines_done, c0_req_addr, c1_req_addr}), 512'(0));
    chk("t6_async_reset_data", c1_req_data, 512'(0));
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_sd.delete(); rdq.delete();
    wr_pending = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    fill(42'hD000, 8'h0F, 1);
    fill(42'hD001, 8'hF0, 1);
    fill(42'hE000, 8'h01, 0);
    fill(42'hE001, 8'h02, 0);
    w0 = wr_cnt;
    write_cfg(42'hD000, 42'hE000, 42'hF000, 2);
    do_start(1'b1);
    wait_done("t6_fresh_done", 1000);
    chk("t6_fresh_writes", 512'(wr_cnt - w0), 512'(2));
    chk("t6_fresh_lines", 512'(lines_done), 512'(2));
    chk("t6_fresh_lane0", 512'(last_wd[7:0]), 512'(8'hF2));
    chk("t6_wr_left", 512'(exp_wa.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
